// File: rtl/adapt_step_scheduler_if.sv
// Slicer-error stream into the adaptation scheduler, plus the commit/step bundle it returns.
// Latency: n/a (signal bundle only); the scheduler registers every output it drives here.
// Backpressure: none; the error stream is qualified by i_err_valid and is never stalled.
//
// Ports: i_err/i_err_valid flow from the slicer side to the scheduler;
//        o_update_en/o_mu_cma/o_mu_lms flow from the scheduler to the adaptation engine.
interface adapt_step_scheduler_if #(
  parameter int NB_E  = 18,
  parameter int NB_MU = 16
);
  logic signed [NB_E-1:0]  i_err;
  logic                    i_err_valid;
  logic                    o_update_en;
  logic signed [NB_MU-1:0] o_mu_cma;
  logic signed [NB_MU-1:0] o_mu_lms;

  // master: the scheduler (consumes error samples, drives commit strobe and step sizes)
  modport master (
    input  i_err, i_err_valid,
    output o_update_en, o_mu_cma, o_mu_lms
  );

  // slave: the engine/slicer side
  modport slave (
    output i_err, i_err_valid,
    input  o_update_en, o_mu_cma, o_mu_lms
  );
endinterface

// File: rtl/adapt_step_scheduler.sv
// FFE adaptation sequencer: STARTUP -> CMA -> LMS (-> FALLBACK -> CMA), window |e| monitor, LMS step annealing.
// Latency: all outputs registered; phase changes one cycle after the deciding condition, window result one cycle after the closing sample.
// Backpressure: none; error samples are consumed whenever i_err_valid is high, commits are gated by o_update_en.
//
// Ports: clk/rst_n/enable plain; eng = error stream in, commit strobe and step sizes out;
//        remaining i_* are quasi-static configuration, remaining o_* are status.
module adapt_step_scheduler #(
  parameter int NB_E          = 18,
  parameter int NB_MU         = 16,
  parameter int LOG2_WIN      = 6,
  parameter int ANNEAL_MAX_SH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  adapt_step_scheduler_if.master  eng,
  input  logic [15:0]             i_startup_delay,
  input  logic [31:0]             i_cma_max,
  input  logic [NB_E-1:0]         i_conv_thr,
  input  logic [3:0]              i_conv_wins,
  input  logic [NB_E-1:0]         i_div_thr,
  input  logic [15:0]             i_anneal_period,
  input  logic [3:0]              i_decim,
  input  logic signed [NB_MU-1:0] i_mu_cma,
  input  logic signed [NB_MU-1:0] i_mu_lms,
  output logic [2:0]              o_phase,
  output logic [2:0]              o_mu_shift,
  output logic [NB_E-1:0]         o_win_mag,
  output logic                    o_win_done,
  output logic [31:0]             o_iter_count,
  output logic [7:0]              o_fallback_count
);
  localparam logic [2:0] ST_STARTUP  = 3'd0;
  localparam logic [2:0] ST_CMA      = 3'd1;
  localparam logic [2:0] ST_LMS      = 3'd2;
  localparam logic [2:0] ST_FALLBACK = 3'd3;

  localparam int              ACC_W    = NB_E + LOG2_WIN;
  localparam logic [NB_E-1:0] MAG_MAX  = {1'b0, {(NB_E-1){1'b1}}};
  localparam logic [NB_E-1:0] MOST_NEG = {1'b1, {(NB_E-1){1'b0}}};
  localparam logic [2:0]      SH_MAX   = 3'(ANNEAL_MAX_SH);

  logic [2:0]              phase_q, phase_d;
  logic [15:0]             startup_cnt_q, startup_cnt_d;
  logic [31:0]             cma_cnt_q, cma_cnt_d;
  logic [3:0]              conv_cnt_q, conv_cnt_d;
  logic [15:0]             anneal_cnt_q, anneal_cnt_d;
  logic [2:0]              shift_q, shift_d;
  logic [3:0]              decim_cnt_q, decim_cnt_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [LOG2_WIN-1:0]     samp_cnt_q, samp_cnt_d;
  logic [NB_E-1:0]         win_mag_q, win_mag_d;
  logic                    win_done_q, win_done_d;
  logic [31:0]             iter_q, iter_d;
  logic [7:0]              fb_q, fb_d;
  logic                    upd_q, upd_d;
  logic signed [NB_MU-1:0] mu_cma_q, mu_cma_d;
  logic signed [NB_MU-1:0] mu_lms_q, mu_lms_d;

  logic [NB_E-1:0]  err_abs;
  logic [ACC_W-1:0] acc_sum;
  logic [3:0]       conv_nxt;
  logic             entry, cma_hit, conv_hit, div_hit, anneal_tick, startup_done;

  // |e| with the most negative code clamped so it stays representable
  always_comb begin
    if (eng.i_err == MOST_NEG)  err_abs = MAG_MAX;
    else if (eng.i_err[NB_E-1]) err_abs = NB_E'(-eng.i_err);
    else                        err_abs = eng.i_err;
  end

  always_comb begin
    phase_d       = phase_q;
    startup_cnt_d = '0;
    cma_cnt_d     = '0;
    conv_cnt_d    = '0;
    anneal_cnt_d  = '0;
    shift_d       = shift_q;
    decim_cnt_d   = '0;
    acc_d         = acc_q;
    samp_cnt_d    = samp_cnt_q;
    win_mag_d     = win_mag_q;
    win_done_d    = 1'b0;
    iter_d        = iter_q;
    fb_d          = fb_q;
    upd_d         = 1'b0;
    mu_cma_d      = '0;
    mu_lms_d      = '0;
    entry         = 1'b0;

    acc_sum = acc_q + ACC_W'(err_abs);

    // convergence counter value including the window that just completed
    conv_nxt = conv_cnt_q;
    if (win_done_q) begin
      if (win_mag_q < i_conv_thr) conv_nxt = (&conv_cnt_q) ? conv_cnt_q : conv_cnt_q + 4'd1;
      else                        conv_nxt = 4'd0;
    end

    cma_hit      = (i_cma_max != 32'd0) && (({1'b0, cma_cnt_q} + 33'd1) >= {1'b0, i_cma_max});
    conv_hit     = (i_conv_wins != 4'd0) && (conv_nxt >= i_conv_wins);
    div_hit      = win_done_q && (win_mag_q > i_div_thr);
    anneal_tick  = (i_anneal_period != 16'd0) &&
                   (({1'b0, anneal_cnt_q} + 17'd1) >= {1'b0, i_anneal_period});
    startup_done = startup_cnt_q >= ((i_startup_delay == 16'd0) ? 16'd0 : i_startup_delay - 16'd1);

    if (!enable) begin
      // everything back to reset values except the fallback event count
      phase_d    = ST_STARTUP;
      shift_d    = '0;
      acc_d      = '0;
      samp_cnt_d = '0;
      win_mag_d  = '0;
      iter_d     = '0;
    end else begin
      case (phase_q)
        ST_STARTUP:  if (startup_done) phase_d = ST_CMA;
        ST_CMA:      if (cma_hit || conv_hit) phase_d = ST_LMS;
        ST_LMS:      if (div_hit) phase_d = ST_FALLBACK;
        ST_FALLBACK: phase_d = ST_CMA;
        default:     phase_d = ST_STARTUP;
      endcase
      entry = (phase_d != phase_q);

      // A window that would close on a phase-entry cycle is dropped, so every
      // phase only ever judges windows made entirely of its own samples.
      if (entry) begin
        acc_d      = '0;
        samp_cnt_d = '0;
      end else if (eng.i_err_valid) begin
        samp_cnt_d = samp_cnt_q + LOG2_WIN'(1);
        if (&samp_cnt_q) begin
          acc_d      = '0;
          win_mag_d  = acc_sum[ACC_W-1:LOG2_WIN];
          win_done_d = 1'b1;
        end else begin
          acc_d = acc_sum;
        end
      end

      // per-phase counters only run while the phase is held; entry clears them
      if (!entry) begin
        case (phase_q)
          ST_STARTUP: startup_cnt_d = startup_cnt_q + 16'd1;
          ST_CMA: begin
            cma_cnt_d  = (&cma_cnt_q) ? cma_cnt_q : cma_cnt_q + 32'd1;
            conv_cnt_d = conv_nxt;
          end
          ST_LMS: begin
            anneal_cnt_d = anneal_tick ? 16'd0 : anneal_cnt_q + 16'd1;
            if (anneal_tick && (shift_q < SH_MAX)) shift_d = shift_q + 3'd1;
          end
          default: ;
        endcase
      end

      if (entry && (phase_d == ST_CMA))      shift_d = '0;
      if (entry && (phase_d == ST_FALLBACK)) fb_d = (&fb_q) ? fb_q : fb_q + 8'd1;

      if ((phase_q == ST_CMA) || (phase_q == ST_LMS))
        iter_d = (&iter_q) ? iter_q : iter_q + 32'd1;

      // commit strobe on the first cycle of a phase, then every i_decim+1 cycles
      if ((phase_d == ST_CMA) || (phase_d == ST_LMS)) begin
        if (entry || (decim_cnt_q >= i_decim)) upd_d = 1'b1;
        else                                   decim_cnt_d = decim_cnt_q + 4'd1;
      end

      if (phase_d == ST_CMA) mu_cma_d = i_mu_cma;
      if (phase_d == ST_LMS) mu_lms_d = i_mu_lms >>> shift_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q       <= ST_STARTUP;
      startup_cnt_q <= '0;
      cma_cnt_q     <= '0;
      conv_cnt_q    <= '0;
      anneal_cnt_q  <= '0;
      shift_q       <= '0;
      decim_cnt_q   <= '0;
      acc_q         <= '0;
      samp_cnt_q    <= '0;
      win_mag_q     <= '0;
      win_done_q    <= 1'b0;
      iter_q        <= '0;
      fb_q          <= '0;
      upd_q         <= 1'b0;
      mu_cma_q      <= '0;
      mu_lms_q      <= '0;
    end else begin
      phase_q       <= phase_d;
      startup_cnt_q <= startup_cnt_d;
      cma_cnt_q     <= cma_cnt_d;
      conv_cnt_q    <= conv_cnt_d;
      anneal_cnt_q  <= anneal_cnt_d;
      shift_q       <= shift_d;
      decim_cnt_q   <= decim_cnt_d;
      acc_q         <= acc_d;
      samp_cnt_q    <= samp_cnt_d;
      win_mag_q     <= win_mag_d;
      win_done_q    <= win_done_d;
      iter_q        <= iter_d;
      fb_q          <= fb_d;
      upd_q         <= upd_d;
      mu_cma_q      <= mu_cma_d;
      mu_lms_q      <= mu_lms_d;
    end
  end

  assign o_phase          = phase_q;
  assign o_mu_shift       = shift_q;
  assign o_win_mag        = win_mag_q;
  assign o_win_done       = win_done_q;
  assign o_iter_count     = iter_q;
  assign o_fallback_count = fb_q;
  assign eng.o_update_en  = upd_q;
  assign eng.o_mu_cma     = mu_cma_q;
  assign eng.o_mu_lms     = mu_lms_q;
endmodule

// File: tb/tb_adapt_step_scheduler.sv
// Directed bench for adapt_step_scheduler: walks startup, CMA timeout, annealing, divergence/fallback,
// window convergence, error saturation, enable drop and asynchronous reset.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_adapt_step_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        enable;
  logic [15:0] startup_delay;
  logic [31:0] cma_max;
  logic [17:0] conv_thr;
  logic [3:0]  conv_wins;
  logic [17:0] div_thr;
  logic [15:0] anneal_period;
  logic [3:0]  decim;
  logic signed [15:0] mu_cma;
  logic signed [15:0] mu_lms;

  logic [2:0]  o_phase;
  logic [2:0]  o_mu_shift;
  logic [17:0] o_win_mag;
  logic        o_win_done;
  logic [31:0] o_iter_count;
  logic [7:0]  o_fallback_count;

  adapt_step_scheduler_if #(.NB_E(18), .NB_MU(16)) eng_if ();

  adapt_step_scheduler #(
    .NB_E(18), .NB_MU(16), .LOG2_WIN(6), .ANNEAL_MAX_SH(4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .eng              (eng_if),
    .i_startup_delay  (startup_delay),
    .i_cma_max        (cma_max),
    .i_conv_thr       (conv_thr),
    .i_conv_wins      (conv_wins),
    .i_div_thr        (div_thr),
    .i_anneal_period  (anneal_period),
    .i_decim          (decim),
    .i_mu_cma         (mu_cma),
    .i_mu_lms         (mu_lms),
    .o_phase          (o_phase),
    .o_mu_shift       (o_mu_shift),
    .o_win_mag        (o_win_mag),
    .o_win_done       (o_win_done),
    .o_iter_count     (o_iter_count),
    .o_fallback_count (o_fallback_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n         = 1'b0;
    enable        = 1'b0;
    eng_if.i_err       = '0;
    eng_if.i_err_valid = 1'b0;
    startup_delay = 16'd63;
    cma_max       = 32'd1000;
    conv_thr      = 18'h00000;
    conv_wins     = 4'd0;
    div_thr       = 18'h1FFFF;
    anneal_period = 16'd100;
    decim         = 4'd3;
    mu_cma        = 16'sh1234;
    mu_lms        = 16'sh4000;

    cyc(3);
    chk("rst_phase",    o_phase, 0);
    chk("rst_update",   eng_if.o_update_en, 0);
    chk("rst_mu_cma",   eng_if.o_mu_cma, 0);
    chk("rst_mu_lms",   eng_if.o_mu_lms, 0);
    chk("rst_shift",    o_mu_shift, 0);
    chk("rst_win_mag",  o_win_mag, 0);
    chk("rst_win_done", o_win_done, 0);
    chk("rst_iter",     o_iter_count, 0);
    chk("rst_fb",       o_fallback_count, 0);

    rst_n = 1'b1;
    cyc(2);
    chk("idle_phase", o_phase, 0);

    // startup: 63 enabled cycles in STARTUP, CMA on the 64th
    enable = 1'b1;
    cyc(62);
    chk("startup_hold_phase",  o_phase, 0);
    chk("startup_hold_update", eng_if.o_update_en, 0);
    cyc(1);
    chk("cma_entry_phase",  o_phase, 1);
    chk("cma_entry_update", eng_if.o_update_en, 1);
    chk("cma_entry_mu_cma", eng_if.o_mu_cma, 64'h1234);
    chk("cma_entry_mu_lms", eng_if.o_mu_lms, 0);
    chk("cma_entry_iter",   o_iter_count, 0);

    // decimation 3 -> strobe on CMA cycles 1, 5, 9, ...
    for (int k = 2; k <= 8; k++) begin
      cyc(1);
      chk("cma_decim", eng_if.o_update_en, ((k % 4) == 1) ? 1 : 0);
    end

    // CMA timeout at 1000 cycles
    cyc(992);
    chk("cma_last_phase", o_phase, 1);
    chk("cma_last_iter",  o_iter_count, 999);
    cyc(1);
    chk("lms_entry_phase",  o_phase, 2);
    chk("lms_entry_iter",   o_iter_count, 1000);
    chk("lms_entry_update", eng_if.o_update_en, 1);
    chk("lms_entry_mu_lms", eng_if.o_mu_lms, 64'h4000);
    chk("lms_entry_mu_cma", eng_if.o_mu_cma, 0);

    // annealing every 100 LMS cycles, shift saturates at 4
    cyc(99);
    chk("anneal_pre_shift", o_mu_shift, 0);
    chk("anneal_pre_mu",    eng_if.o_mu_lms, 64'h4000);
    cyc(1);
    chk("anneal1_shift", o_mu_shift, 1);
    chk("anneal1_mu",    eng_if.o_mu_lms, 64'h2000);
    cyc(100);
    chk("anneal2_mu",    eng_if.o_mu_lms, 64'h1000);
    cyc(100);
    chk("anneal3_mu",    eng_if.o_mu_lms, 64'h0800);
    cyc(100);
    chk("anneal4_shift", o_mu_shift, 4);
    chk("anneal4_mu",    eng_if.o_mu_lms, 64'h0400);
    cyc(200);
    chk("anneal_sat_shift", o_mu_shift, 4);
    chk("anneal_sat_mu",    eng_if.o_mu_lms, 64'h0400);

    // divergence: large error window in LMS -> one FALLBACK cycle -> CMA
    eng_if.i_err       = 18'h1FFFF;
    eng_if.i_err_valid = 1'b1;
    div_thr            = 18'h08000;
    cyc(64);
    chk("div_win_done",  o_win_done, 1);
    chk("div_win_mag",   o_win_mag, 64'h1FFFF);
    chk("div_win_phase", o_phase, 2);
    cyc(1);
    chk("fallback_phase",  o_phase, 3);
    chk("fallback_count",  o_fallback_count, 1);
    chk("fallback_update", eng_if.o_update_en, 0);
    chk("fallback_mu_lms", eng_if.o_mu_lms, 0);
    cyc(1);
    chk("refall_cma_phase",  o_phase, 1);
    chk("refall_cma_shift",  o_mu_shift, 0);
    chk("refall_cma_fb",     o_fallback_count, 1);
    chk("refall_cma_update", eng_if.o_update_en, 1);

    // convergence: three quiet windows -> LMS at CMA cycle 194
    eng_if.i_err = 18'h00100;
    conv_thr     = 18'h00200;
    conv_wins    = 4'd3;
    cma_max      = 32'd0;
    cyc(64);
    chk("conv_w1_done",  o_win_done, 1);
    chk("conv_w1_mag",   o_win_mag, 64'h00100);
    chk("conv_w1_phase", o_phase, 1);
    cyc(64);
    chk("conv_w2_done",  o_win_done, 1);
    chk("conv_w2_phase", o_phase, 1);
    cyc(64);
    chk("conv_w3_done",  o_win_done, 1);
    chk("conv_w3_phase", o_phase, 1);
    cyc(1);
    chk("conv_lms_phase", o_phase, 2);
    chk("conv_lms_done",  o_win_done, 0);

    // most negative error saturates to 0x1FFFF and also diverges
    eng_if.i_err = 18'h20000;
    cyc(64);
    chk("neg_sat_done", o_win_done, 1);
    chk("neg_sat_mag",  o_win_mag, 64'h1FFFF);
    cyc(1);
    chk("neg_fallback_phase", o_phase, 3);
    chk("neg_fallback_count", o_fallback_count, 2);
    cyc(1);
    chk("neg_cma_phase", o_phase, 1);

    // short CMA timeout, then drop enable mid-LMS
    eng_if.i_err_valid = 1'b0;
    conv_wins          = 4'd0;
    cma_max            = 32'd5;
    cyc(4);
    chk("short_cma_phase", o_phase, 1);
    cyc(1);
    chk("short_lms_phase", o_phase, 2);
    cyc(3);
    enable = 1'b0;
    cyc(1);
    chk("dis_phase",   o_phase, 0);
    chk("dis_iter",    o_iter_count, 0);
    chk("dis_fb_kept", o_fallback_count, 2);
    chk("dis_update",  eng_if.o_update_en, 0);
    chk("dis_mu_lms",  eng_if.o_mu_lms, 0);
    chk("dis_win_mag", o_win_mag, 0);

    // startup delay of 0 behaves as 1
    startup_delay = 16'd0;
    enable        = 1'b1;
    cyc(1);
    chk("delay0_phase", o_phase, 1);
    cyc(5);
    chk("delay0_lms_phase", o_phase, 2);

    // asynchronous reset mid-LMS
    cyc(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_phase",  o_phase, 0);
    chk("arst_fb",     o_fallback_count, 0);
    chk("arst_iter",   o_iter_count, 0);
    chk("arst_mu_lms", eng_if.o_mu_lms, 0);
    chk("arst_update", eng_if.o_update_en, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
